highlight: RTL and testbench
============================

// Module: highlight
// PURPOSE
// - Consumer of the 1-bit motion mask stream produced by the subtract stage.
// - Pairs each mask bit with the matching original 24-bit RGB pixel and writes an RGB pixel to the output FIFO:
//   - unchanged pixels pass through;
//   - motion pixels are replaced by HIGHLIGHT.
// - Counts motion pixels per frame and pulses frame_done after the last pixel of each frame.
// - Sits between the mask/frame FIFOs and the image writer.
// PARAMETERS
// WIDTH      720         pixels per line
// HEIGHT     540         lines per frame
// HIGHLIGHT  24'hFF0000  RGB written for motion pixels
// CNT_W      $clog2(WIDTH*HEIGHT+1)  motion counter width (derived, do not override)
// PORTS
// clock         in   1      system clock
// reset         in   1      asynchronous, active-high reset
// mask_rd_en    out  1      pop mask FIFO
// mask_empty    in   1      mask FIFO empty
// mask_dout     in   1      mask bit: 1 = unchanged (|diff| <= 50), 0 = motion
// pix_rd_en     out  1      pop original-pixel FIFO
// pix_empty     in   1      pixel FIFO empty
// pix_dout      in   24     original RGB pixel {R,G,B}
// out_wr_en     out  1      push output FIFO
// out_full      in   1      output FIFO full
// out_din       out  24     output RGB pixel
// motion_count  out  CNT_W  motion pixels in last completed frame (held)
// frame_done    out  1      one-cycle pulse after a frame's last pixel is written
// BEHAVIOUR
// - FIFOs are first-word-fall-through: dout is valid whenever empty==0; rd_en pops.
// - FSM states: S_READ, S_WRITE.
//   - Reset state is S_READ.
//   - All registers clear to 0, so motion_count=0 and frame_done=0.
// - S_READ:
//   - Fires only when mask_empty==0 AND pix_empty==0.
//   - On firing:
//     - assert mask_rd_en and pix_rd_en in the same cycle, never one without the other;
//     - register pixel = mask_dout ? pix_dout : HIGHLIGHT;
//     - register is_motion = ~mask_dout;
//     - go to S_WRITE.
//   - Otherwise hold in S_READ with no reads.
// - S_WRITE:
//   - If out_full==0:
//     - assert out_wr_en with out_din = registered pixel;
//     - advance the col/row counters and add is_motion to the motion accumulator;
//     - go to S_READ.
//   - If out_full==1: hold in S_WRITE with registered data stable and out_wr_en=0.
// - out_din is 0 whenever out_wr_en==0. rd_en and wr_en are never asserted in the same cycle.
// - Throughput: at most 1 pixel per 2 cycles. Latency from read to write is 1 cycle when out_full==0.
// - col counts 0..WIDTH-1; row counts 0..HEIGHT-1.
//   - col wraps to 0 with row+1.
//   - At col==WIDTH-1 && row==HEIGHT-1 the write completes the frame.
// - On the frame-completing write:
//   - next cycle, frame_done=1 for exactly one cycle;
//   - motion_count updates in that same cycle to the final accumulator value, including the last pixel;
//   - accumulator, col and row clear to 0.
// - The accumulator has CNT_W bits and can never overflow; all-motion frame gives WIDTH*HEIGHT.
// - Simultaneous events: last write of frame N and the first read of frame N+1 cannot share a cycle (FSM), so no conflict exists.
// - Reset mid-frame: partial counts are discarded; the frame restarts at col=row=0.
//   - Data already popped but not yet written is lost.
//   - Upstream FIFOs are reset by the same reset.
// - No X outputs from any reachable state. The default branch returns to S_READ with all strobes 0.
// STRUCTURE
// - motion_pkg: state enum (S_READ, S_WRITE), pixel type logic [23:0], mask polarity constant MASK_STILL=1'b1, and the HIGHLIGHT default.
// - One sub-module, frame_counter:
//   - inputs: clock, reset, advance, is_motion;
//   - outputs: last_pixel, frame_done, motion_count;
//   - holds col/row/accumulator.
// - The FSM and datapath register stay in highlight.
// TESTING
// - Use WIDTH=4, HEIGHT=2 for short frames unless noted.
// 1. Reset: assert reset mid-operation -> all outputs 0 and state S_READ next cycle; no rd_en/wr_en while reset is high.
// 2. Pass/replace:
//    - mask=1, pix=24'h123456 -> out_din=24'h123456;
//    - mask=0, pix=24'h123456 -> out_din=24'hFF0000;
//    - one write per read pair.
// 3. Empty skew:
//    - mask FIFO non-empty, pixel FIFO empty for 5 cycles -> no rd_en on either FIFO;
//    - when the pixel FIFO fills, both pop in one cycle.
// 4. Backpressure:
//    - out_full=1 for 3 cycles while in S_WRITE -> out_wr_en=0, no further reads, registered pixel unchanged;
//    - write occurs the cycle out_full drops.
// 5. Frame stats:
//    - 8 pixels with masks 0,1,1,0,0,1,1,0 -> single frame_done pulse after the 8th write, motion_count=4;
//    - next frame all 1 -> motion_count=0.
// 6. Full throughput: FIFOs never empty/full, 2 frames -> 16 writes in 32 cycles and 2 frame_done pulses exactly 16 cycles apart.

Source files
------------

// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the motion highlight stage.
package motion_pkg;
   typedef enum logic {S_READ = 1'b0, S_WRITE = 1'b1} state_t;
   typedef logic [23:0] pixel_t;
   localparam logic MASK_STILL = 1'b1;
   localparam pixel_t HIGHLIGHT_DEFAULT = 24'hFF0000;
endpackage

// File: rtl/frame_counter.sv
// frame_counter: raster position tracking and per-frame motion pixel tally.
module frame_counter #(
   parameter int WIDTH = 720,
   parameter int HEIGHT = 540,
   localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             advance,
   input  logic             is_motion,
   output logic             last_pixel,
   output logic             frame_done,
   output logic [CNT_W-1:0] motion_count
);
   localparam int COL_W = $clog2(WIDTH + 1);
   localparam int ROW_W = $clog2(HEIGHT + 1);
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_next;
   logic             end_of_line;
   assign end_of_line = col == COL_W'(WIDTH - 1);
   assign last_pixel = end_of_line && row == ROW_W'(HEIGHT - 1);
   assign acc_next = acc + CNT_W'(is_motion);
   // acc_next includes the pixel being written, so the published count covers the whole frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
         acc <= '0;
         motion_count <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= advance && last_pixel;
         if (advance) begin
            if (last_pixel) begin
               col <= '0;
               row <= '0;
               acc <= '0;
               motion_count <= acc_next;
            end else begin
               col <= end_of_line ? '0 : col + 1'b1;
               row <= end_of_line ? row + 1'b1 : row;
               acc <= acc_next;
            end
         end
      end
   end
endmodule

// File: rtl/highlight.sv
// highlight: merges mask and pixel streams, replacing motion pixels with a highlight colour.
module highlight
   import motion_pkg::*;
#(
   parameter int     WIDTH = 720,
   parameter int     HEIGHT = 540,
   parameter pixel_t HIGHLIGHT = HIGHLIGHT_DEFAULT,
   localparam int    CNT_W = $clog2(WIDTH * HEIGHT + 1)
) (
   input  logic             clock,
   input  logic             reset,
   output logic             mask_rd_en,
   input  logic             mask_empty,
   input  logic             mask_dout,
   output logic             pix_rd_en,
   input  logic             pix_empty,
   input  logic [23:0]      pix_dout,
   output logic             out_wr_en,
   input  logic             out_full,
   output logic [23:0]      out_din,
   output logic [CNT_W-1:0] motion_count,
   output logic             frame_done
);
   state_t state;
   state_t state_next;
   pixel_t pixel_q;
   logic   motion_q;
   logic   avail;
   logic   last_pixel;
   assign avail = !mask_empty && !pix_empty;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_READ;
      else state <= state_next;
   end
   always_comb begin
      state_next = S_READ;
      case (state)
         S_READ:  state_next = avail ? S_WRITE : S_READ;
         S_WRITE: state_next = out_full ? S_WRITE : S_READ;
         default: state_next = S_READ;
      endcase
   end
   // strobes are held low while reset is asserted so nothing is popped or pushed during it
   always_comb begin
      mask_rd_en = 1'b0;
      pix_rd_en = 1'b0;
      out_wr_en = 1'b0;
      case (state)
         S_READ: begin
            mask_rd_en = avail && !reset;
            pix_rd_en = avail && !reset;
         end
         S_WRITE: out_wr_en = !out_full && !reset;
         default: out_wr_en = 1'b0;
      endcase
      out_din = out_wr_en ? pixel_q : '0;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pixel_q <= '0;
         motion_q <= 1'b0;
      end else if (mask_rd_en) begin
         pixel_q <= mask_dout == MASK_STILL ? pix_dout : HIGHLIGHT;
         motion_q <= mask_dout != MASK_STILL;
      end
   end
   frame_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_frame_counter (
      .clock(clock),
      .reset(reset),
      .advance(out_wr_en),
      .is_motion(motion_q),
      .last_pixel(last_pixel),
      .frame_done(frame_done),
      .motion_count(motion_count)
   );
   logic unused_last_pixel;
   assign unused_last_pixel = last_pixel;
endmodule

// File: tb/tb_highlight.sv
// tb_highlight: vector table, corner sequences and randomized scoreboard for highlight.
module tb_highlight;
   localparam int W = 4;
   localparam int H = 2;
   localparam int CW = $clog2(W * H + 1);
   localparam logic [23:0] HL = 24'hFF0000;
   typedef struct {
      logic        m;
      logic [23:0] p;
      int          full;
      logic [23:0] e;
   } vec_t;
   typedef struct {
      logic [23:0] pix;
      int          mot;
   } exp_t;
   logic          clock, reset;
   logic          mask_rd_en, mask_empty, mask_dout;
   logic          pix_rd_en, pix_empty;
   logic [23:0]   pix_dout;
   logic          out_wr_en, out_full;
   logic [23:0]   out_din;
   logic [CW-1:0] motion_count;
   logic          frame_done;
   int            passed = 0, total = 0;
   logic          mq[$];
   logic [23:0]   pq[$];
   exp_t          expq[$];
   int            nwr = 0, acc = 0, mc_exp = 0;
   logic          done_pend = 1'b0;
   logic          s_mrd, s_prd, s_wr, s_done;
   logic [23:0]   s_din;
   vec_t          v[8];

   highlight #(.WIDTH(W), .HEIGHT(H)) dut (
      .clock(clock), .reset(reset),
      .mask_rd_en(mask_rd_en), .mask_empty(mask_empty), .mask_dout(mask_dout),
      .pix_rd_en(pix_rd_en), .pix_empty(pix_empty), .pix_dout(pix_dout),
      .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
      .motion_count(motion_count), .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive();
      mask_empty = mq.size() == 0;
      mask_dout = mask_empty ? 1'b0 : mq[0];
      pix_empty = pq.size() == 0;
      pix_dout = pix_empty ? 24'h0 : pq[0];
   endtask

   // one clock: observe at negedge against the model, then update FIFOs just after posedge
   task automatic cyc();
      logic ok;
      exp_t e;
      @(negedge clock);
      s_mrd = mask_rd_en; s_prd = pix_rd_en; s_wr = out_wr_en; s_din = out_din; s_done = frame_done;
      if (reset) begin
         chk("reset_outputs", {mask_rd_en, pix_rd_en, out_wr_en, frame_done, out_din, motion_count}, 32'h0);
      end else begin
         ok = (mask_rd_en == pix_rd_en) && !((mask_rd_en || pix_rd_en) && out_wr_en)
              && (out_wr_en || out_din == 24'h0) && !(mask_rd_en && (mask_empty || pix_empty))
              && !(out_wr_en && out_full);
         chk("strobe_rules", 32'(ok), 32'd1);
         chk("frame_done", 32'(frame_done), 32'(done_pend));
         chk("motion_count", 32'(motion_count), 32'(mc_exp));
         done_pend = 1'b0;
         if (out_wr_en) begin
            if (expq.size() == 0) chk("spurious_write", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               chk("out_din", 32'(out_din), 32'(e.pix));
               acc += e.mot;
               nwr++;
               if (nwr == W * H) begin
                  done_pend = 1'b1;
                  mc_exp = acc;
                  nwr = 0;
                  acc = 0;
               end
            end
         end
      end
      @(posedge clock);
      #1;
      if (s_mrd && s_prd && mq.size() > 0 && pq.size() > 0) begin
         logic m;
         logic [23:0] p;
         m = mq.pop_front();
         p = pq.pop_front();
         expq.push_back('{m ? p : HL, m ? 0 : 1});
      end else begin
         if (s_mrd && mq.size() > 0) void'(mq.pop_front());
         if (s_prd && pq.size() > 0) void'(pq.pop_front());
      end
      drive();
   endtask

   task automatic run_vec(input vec_t t);
      mq.push_back(t.m);
      pq.push_back(t.p);
      out_full = t.full != 0;
      drive();
      cyc();
      chk("vec_read", {s_mrd, s_prd}, 32'd3);
      for (int k = 0; k < t.full; k++) begin
         cyc();
         chk("bp_hold", {s_wr, s_mrd, s_prd}, 32'd0);
      end
      out_full = 1'b0;
      cyc();
      chk("vec_write", 32'(s_wr), 32'd1);
      chk("vec_data", 32'(s_din), 32'(t.e));
   endtask

   initial begin
      int writes, ndone, d0, d1, budget;
      v[0] = '{1'b0, 24'h123456, 0, HL};
      v[1] = '{1'b1, 24'h123456, 0, 24'h123456};
      v[2] = '{1'b1, 24'h00FF00, 3, 24'h00FF00};
      v[3] = '{1'b0, 24'hFF0000, 0, HL};
      v[4] = '{1'b0, 24'h000000, 1, HL};
      v[5] = '{1'b1, 24'hFFFFFF, 0, 24'hFFFFFF};
      v[6] = '{1'b1, 24'h000000, 0, 24'h000000};
      v[7] = '{1'b0, 24'hABCDEF, 2, HL};
      reset = 1'b1;
      out_full = 1'b0;
      drive();
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      // frame with four motion pixels, including backpressure stalls
      for (int i = 0; i < 8; i++) run_vec(v[i]);
      chk("frame1_done", 32'(frame_done), 32'd1);
      chk("frame1_count", 32'(motion_count), 32'd4);
      for (int i = 0; i < 8; i++) begin
         logic [23:0] px;
         px = 24'($urandom);
         run_vec('{1'b1, px, 0, px});
      end
      chk("frame2_done", 32'(frame_done), 32'd1);
      chk("frame2_count", 32'(motion_count), 32'd0);
      cyc();
      // full throughput across two frames
      for (int i = 0; i < 16; i++) begin
         mq.push_back(1'($urandom_range(0, 1)));
         pq.push_back(24'($urandom));
      end
      drive();
      writes = 0; ndone = 0; d0 = 0; d1 = 0;
      for (int i = 0; i < 34; i++) begin
         cyc();
         if (i < 32 && s_wr) writes++;
         if (s_done) begin
            if (ndone == 0) d0 = i;
            else d1 = i;
            ndone++;
         end
      end
      chk("tput_writes", 32'(writes), 32'd16);
      chk("tput_done_pulses", 32'(ndone), 32'd2);
      chk("tput_done_spacing", 32'(d1 - d0), 32'd16);
      // mask available while pixel FIFO stays empty
      mq.push_back(1'b1);
      drive();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("skew_no_read", {s_mrd, s_prd}, 32'd0);
      end
      pq.push_back(24'h13579B);
      drive();
      cyc();
      chk("skew_pop_both", {s_mrd, s_prd}, 32'd3);
      cyc();
      chk("skew_data", 32'(s_din), 32'h13579B);
      repeat (300) begin
         if (mq.size() < 4 && $urandom_range(0, 2) != 0) mq.push_back(1'($urandom_range(0, 1)));
         if (pq.size() < 4 && $urandom_range(0, 2) != 0) pq.push_back(24'($urandom));
         out_full = $urandom_range(0, 3) == 0;
         drive();
         cyc();
      end
      // reset while a popped pixel is stalled in the output stage
      mq.push_back(1'b0);
      pq.push_back(24'h2468AC);
      out_full = 1'b1;
      drive();
      repeat (12) cyc();
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", {mask_rd_en, pix_rd_en, out_wr_en, frame_done, out_din, motion_count}, 32'h0);
      repeat (2) cyc();
      reset = 1'b0;
      mq.delete(); pq.delete(); expq.delete();
      nwr = 0; acc = 0; mc_exp = 0; done_pend = 1'b0;
      out_full = 1'b0;
      drive();
      repeat (200) begin
         if (mq.size() < 4 && $urandom_range(0, 1) != 0) mq.push_back(1'($urandom_range(0, 1)));
         if (pq.size() < 4 && $urandom_range(0, 1) != 0) pq.push_back(24'($urandom));
         out_full = $urandom_range(0, 4) == 0;
         drive();
         cyc();
      end
      out_full = 1'b0;
      drive();
      budget = 0;
      while ((expq.size() > 0 || (mq.size() > 0 && pq.size() > 0)) && budget < 200) begin
         cyc();
         budget++;
      end
      cyc();
      chk("drain", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
